// File: rtl/tl_pkg.sv
// -----------------------------------------------------------------------------
// tl_pkg
// Shared definitions for the intersection traffic-light blocks (phase
// scheduler, light controller, lamp drivers).
//   - Lamp encoding constants RED / YELLOW / GREEN (2-bit)
//   - Phase (state) encoding shared by every consumer of the phase status
// -----------------------------------------------------------------------------
package tl_pkg;

    // Lamp encoding on the 2-bit light buses.
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] GREEN  = 2'b10;

    // Phase encoding; codes 6 and 7 are illegal.
    typedef enum logic [2:0] {
        StHwyG  = 3'd0,
        StHwyY  = 3'd1,
        StRedA  = 3'd2,
        StFarmG = 3'd3,
        StFarmY = 3'd4,
        StRedB  = 3'd5
    } phase_e;

endpackage

// File: rtl/tl_dwell_timer.sv
// -----------------------------------------------------------------------------
// tl_dwell_timer
// Saturating dwell counter for one phase, advanced by the time-base tick,
// with two elapsed comparators evaluated against the current count.
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   clr_i        in   clear count to 0 (phase change)
//   tick_i       in   time-base strobe; count advances only when set
//   dur_a_i      in   first dwell threshold in ticks
//   dur_b_i      in   second dwell threshold in ticks
//   elapsed_a_o  out  count + tick >= dur_a_i
//   elapsed_b_o  out  count + tick >= dur_b_i
// -----------------------------------------------------------------------------
module tl_dwell_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] dur_a_i,
    input  logic [CNT_W-1:0] dur_b_i,
    output logic             elapsed_a_o,
    output logic             elapsed_b_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W:0]   count_plus_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (tick_i && (count_q != '1)) begin
            // Holds at all-ones so a long idle dwell never wraps and re-triggers.
            count_q <= count_q + CNT_W'(1);
        end
    end

    // One extra bit so a saturated count plus the tick cannot overflow.
    always_comb begin
        count_plus_tick = {1'b0, count_q} + (CNT_W + 1)'(tick_i);
        elapsed_a_o     = (count_plus_tick >= {1'b0, dur_a_i});
        elapsed_b_o     = (count_plus_tick >= {1'b0, dur_b_i});
    end

endmodule

// File: rtl/tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tl_phase_scheduler
// Timed phase sequencer for the highway / farm-road intersection with a
// latched pedestrian request served during farm green.
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   tick           in   one-cycle time-base strobe
//   farm_sensor_X  in   vehicle present on farm road (level)
//   ped_req        in   pedestrian crossing request (pulse or level)
//   hwy_TL         out  highway lamp (RED/YELLOW/GREEN)
//   fwy_TL         out  farm-road lamp (RED/YELLOW/GREEN)
//   walk           out  pedestrian walk lamp (registered)
//   phase          out  current phase code
// All outputs come from registered state; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module tl_phase_scheduler
    import tl_pkg::*;
#(
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned HWY_MIN_GREEN  = 20,
    parameter int unsigned FARM_MIN_GREEN = 5,
    parameter int unsigned FARM_MAX_GREEN = 15,
    parameter int unsigned YELLOW_TIME    = 4,
    parameter int unsigned ALL_RED_TIME   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       farm_sensor_X,
    input  logic       ped_req,
    output logic [1:0] hwy_TL,
    output logic [1:0] fwy_TL,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] HwyMinG  = CNT_W'(HWY_MIN_GREEN);
    localparam logic [CNT_W-1:0] FarmMinG = CNT_W'(FARM_MIN_GREEN);
    localparam logic [CNT_W-1:0] FarmMaxG = CNT_W'(FARM_MAX_GREEN);
    localparam logic [CNT_W-1:0] YellowT  = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] AllRedT  = CNT_W'(ALL_RED_TIME);

    phase_e           state_q, state_d;
    logic             ped_pending_q, ped_pending_d;
    logic             walk_q, walk_d;
    logic [CNT_W-1:0] dur_a, dur_b;
    logic             elapsed_a, elapsed_b;
    logic             timer_clr;

    // Threshold A is the phase's main dwell; B is only meaningful in farm green.
    always_comb begin
        dur_a = YellowT;
        dur_b = FarmMaxG;
        case (state_q)
            StHwyG:          dur_a = HwyMinG;
            StHwyY, StFarmY: dur_a = YellowT;
            StRedA, StRedB:  dur_a = AllRedT;
            StFarmG:         dur_a = FarmMinG;
            default:         dur_a = YellowT;
        endcase
    end

    tl_dwell_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (timer_clr),
        .tick_i      (tick),
        .dur_a_i     (dur_a),
        .dur_b_i     (dur_b),
        .elapsed_a_o (elapsed_a),
        .elapsed_b_o (elapsed_b)
    );

    always_comb begin
        state_d       = state_q;
        ped_pending_d = ped_pending_q;
        walk_d        = walk_q;
        if (ped_req) begin
            ped_pending_d = 1'b1;
        end
        case (state_q)
            StHwyG: begin
                if (elapsed_a && (farm_sensor_X || ped_pending_q || ped_req)) begin
                    state_d = StHwyY;
                end
            end
            StHwyY: begin
                if (elapsed_a) state_d = StRedA;
            end
            StRedA: begin
                if (elapsed_a) begin
                    // A request arriving on this edge is served now, not latched.
                    state_d       = StFarmG;
                    walk_d        = ped_pending_q || ped_req;
                    ped_pending_d = 1'b0;
                end
            end
            StFarmG: begin
                if ((elapsed_a && !farm_sensor_X) || elapsed_b) begin
                    state_d = StFarmY;
                    walk_d  = 1'b0;
                end
            end
            StFarmY: begin
                if (elapsed_a) state_d = StRedB;
            end
            StRedB: begin
                if (elapsed_a) state_d = StHwyG;
            end
            default: state_d = StHwyG;
        endcase
    end

    assign timer_clr = (state_d != state_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StHwyG;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
        end
    end

    // Moore lamp decode; illegal codes show highway green.
    always_comb begin
        hwy_TL = GREEN;
        fwy_TL = RED;
        case (state_q)
            StHwyG:         begin hwy_TL = GREEN;  fwy_TL = RED;    end
            StHwyY:         begin hwy_TL = YELLOW; fwy_TL = RED;    end
            StRedA, StRedB: begin hwy_TL = RED;    fwy_TL = RED;    end
            StFarmG:        begin hwy_TL = RED;    fwy_TL = GREEN;  end
            StFarmY:        begin hwy_TL = RED;    fwy_TL = YELLOW; end
            default:        begin hwy_TL = GREEN;  fwy_TL = RED;    end
        endcase
    end

    assign walk  = walk_q;
    assign phase = state_q;

endmodule

// File: tb/tb_tl_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tl_phase_scheduler
// Directed and randomized stimulus for tl_phase_scheduler, checked every
// cycle against a phase/tick-count reference model plus directed constants.
// -----------------------------------------------------------------------------
module tb_tl_phase_scheduler;

    localparam int HMIN = 4;
    localparam int FMIN = 2;
    localparam int FMAX = 6;
    localparam int YT   = 2;
    localparam int ART  = 1;
    localparam int SAT  = 255;

    logic       clk = 1'b0;
    logic       rst, tick, farm_sensor_X, ped_req;
    logic [1:0] hwy_TL, fwy_TL;
    logic       walk;
    logic [2:0] phase;

    always #5 clk = ~clk;

    tl_phase_scheduler #(
        .CNT_W          (8),
        .HWY_MIN_GREEN  (HMIN),
        .FARM_MIN_GREEN (FMIN),
        .FARM_MAX_GREEN (FMAX),
        .YELLOW_TIME    (YT),
        .ALL_RED_TIME   (ART)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .farm_sensor_X (farm_sensor_X),
        .ped_req       (ped_req),
        .hwy_TL        (hwy_TL),
        .fwy_TL        (fwy_TL),
        .walk          (walk),
        .phase         (phase)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: phase index 0..5 in ring order, ticks spent in it.
    int m_ph = 0, m_t = 0, m_pend = 0, m_walk = 0;
    int dwell[6]  = '{HMIN, YT, ART, FMIN, YT, ART};
    int lamp_h[6] = '{2, 1, 0, 0, 0, 0};
    int lamp_f[6] = '{0, 0, 0, 2, 1, 0};

    task automatic model(input bit r, input bit tk, input bit sn, input bit pd);
        int  s;
        bit  ex;
        if (r) begin
            m_ph = 0; m_t = 0; m_pend = 0; m_walk = 0;
            return;
        end
        s = m_t + int'(tk);
        if (m_ph == 0)      ex = (s >= HMIN) && (sn || m_pend != 0 || pd);
        else if (m_ph == 3) ex = ((s >= FMIN) && !sn) || (s >= FMAX);
        else                ex = (s >= dwell[m_ph]);
        if (m_ph == 2 && ex) begin
            m_walk = (m_pend != 0 || pd) ? 1 : 0;
            m_pend = 0;
        end else if (pd) begin
            m_pend = 1;
        end
        if (m_ph == 3 && ex) m_walk = 0;
        if (ex) begin
            m_ph = (m_ph + 1) % 6;
            m_t  = 0;
        end else begin
            m_t = (s > SAT) ? SAT : s;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance model and DUT, then compare.
    task automatic step(input bit r, input bit tk, input bit sn, input bit pd);
        rst = r; tick = tk; farm_sensor_X = sn; ped_req = pd;
        model(r, tk, sn, pd);
        @(posedge clk);
        #1;
        cyc = r ? 0 : cyc + 1;
        check("phase", {1'b0, phase}, 4'(m_ph));
        check("hwy_TL", {2'b00, hwy_TL}, 4'(lamp_h[m_ph]));
        check("fwy_TL", {2'b00, fwy_TL}, 4'(lamp_f[m_ph]));
        check("walk", {3'b000, walk}, 4'(m_walk));
    endtask

    initial begin
        int seq[17] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 4, 4, 5, 0};
        int cnt, cnt2, first_y, first_r;
        bit sn;

        rst = 1'b1; tick = 1'b1; farm_sensor_X = 1'b0; ped_req = 1'b0;

        // Reset values and idle highway green.
        step(1, 1, 0, 0);
        check("rst_phase", {1'b0, phase}, 4'd0);
        check("rst_hwy", {2'b00, hwy_TL}, 4'd2);
        check("rst_fwy", {2'b00, fwy_TL}, 4'd0);
        check("rst_walk", {3'b000, walk}, 4'd0);
        repeat (50) step(0, 1, 0, 0);
        check("idle_phase", {1'b0, phase}, 4'd0);

        // Sensor held high: full cycle with max-green cut-off.
        step(1, 1, 1, 0);
        check("seq0", {1'b0, phase}, 4'(seq[0]));
        for (int k = 1; k < 17; k++) begin
            step(0, 1, 1, 0);
            check("seq", {1'b0, phase}, 4'(seq[k]));
        end

        // One-cycle sensor pulse: farm green limited to minimum.
        step(1, 1, 0, 0);
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            step(0, 1, c == 10, 0);
            if (phase == 3'd3) cnt++;
        end
        check("min_green_len", 4'(cnt), 4'(FMIN));

        // Single pedestrian pulse: walk only for the farm green interval.
        step(1, 1, 0, 0);
        cnt = 0; cnt2 = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 1, 0, c == 1);
            if (walk) cnt++;
            if (phase == 3'd1) cnt2++;
        end
        check("walk_len", 4'(cnt), 4'd2);
        check("one_crossing", 4'(cnt2), 4'(YT));

        // Second request during farm green triggers one more crossing.
        step(1, 1, 0, 0);
        cnt = 0; cnt2 = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 1, 0, c == 1 || c == 8);
            if (walk) cnt++;
            if (phase == 3'd1) cnt2++;
        end
        check("walk_len2", 4'(cnt), 4'd4);
        check("two_crossings", 4'(cnt2), 4'(2 * YT));

        // Tick 1-in-3: dwells stretched threefold.
        step(1, 1, 1, 0);
        first_y = -1; first_r = -1;
        for (int c = 0; c < 60; c++) begin
            step(0, (c % 3) == 2, 1, 0);
            if (phase == 3'd1 && first_y < 0) first_y = cyc;
            if (phase == 3'd2 && first_r < 0) first_r = cyc;
        end
        check("slow_hwy_g", 4'(first_y), 4'd12);
        check("slow_hwy_y", 4'(first_r - first_y), 4'd6);

        // Reset in farm green with walk lit.
        step(1, 1, 1, 0);
        for (int c = 0; c < 9; c++) step(0, 1, 1, c == 1);
        check("pre_rst_phase", {1'b0, phase}, 4'd3);
        check("pre_rst_walk", {3'b000, walk}, 4'd1);
        step(1, 1, 1, 0);
        check("mid_rst_phase", {1'b0, phase}, 4'd0);
        check("mid_rst_hwy", {2'b00, hwy_TL}, 4'd2);
        check("mid_rst_fwy", {2'b00, fwy_TL}, 4'd0);
        check("mid_rst_walk", {3'b000, walk}, 4'd0);
        first_y = -1;
        for (int c = 0; c < 8; c++) begin
            step(0, 1, 1, 0);
            if (phase == 3'd1 && first_y < 0) first_y = cyc;
        end
        check("timer_restart", 4'(first_y), 4'(HMIN));

        // Long idle saturates the timer; demand then leaves at once.
        step(1, 1, 0, 0);
        repeat (300) step(0, 1, 0, 0);
        check("sat_hold", {1'b0, phase}, 4'd0);
        step(0, 1, 1, 0);
        check("sat_exit", {1'b0, phase}, 4'd1);

        // Randomized traffic against the model.
        sn = 1'b0;
        step(1, 1, 0, 0);
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) sn = ~sn;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, sn,
                 $urandom_range(0, 29) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
